// File: rtl/emg_envelope.sv
// EMG envelope extraction: DC baseline removal, full-wave rectification,
// power-of-two moving average and saturated 8-bit output, with baseline calibration.
module emg_envelope #(
   parameter int SW       = 12,
   parameter int LOG2_WIN = 4,
   parameter int LOG2_CAL = 6,
   parameter int SHIFT    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [SW-1:0] sample_in,
   input  logic          sample_valid,
   input  logic          cal_start,
   output logic [7:0]    env_out,
   output logic          env_valid,
   output logic          cal_busy,
   output logic          cal_done
);
   localparam int WIN    = 1 << LOG2_WIN;
   localparam int SUMW   = SW + LOG2_WIN;
   localparam int ACCW   = SW + LOG2_CAL;
   localparam int STAGES = 1;

   typedef enum logic {RUN, CAL} state_t;

   state_t              state;
   logic [SW-1:0]       baseline;
   logic [SW-1:0]       win_buf [WIN];
   logic [LOG2_WIN-1:0] wr_ptr;
   logic [SUMW-1:0]     sum;
   logic [SW-1:0]       rect_q;
   logic [ACCW-1:0]     acc;
   logic [LOG2_CAL-1:0] cal_cnt;
   logic [STAGES:0]     vld_pipe;

   logic signed [SW:0]  diff;
   logic [SW-1:0]       rect;
   logic [SUMW-1:0]     sum_next;
   logic [SUMW-1:0]     scaled;
   logic [ACCW-1:0]     acc_next;
   logic                run_accept, cal_enter, cal_accept, cal_last;

   always_comb begin
      diff       = $signed({1'b0, sample_in}) - $signed({1'b0, baseline});
      rect       = diff[SW] ? SW'(-diff) : diff[SW-1:0];
      sum_next   = sum + SUMW'(rect_q) - SUMW'(win_buf[wr_ptr]);
      scaled     = sum >> (LOG2_WIN + SHIFT);
      acc_next   = acc + ACCW'(sample_in);
      run_accept = (state == RUN) && sample_valid && !cal_start;
      cal_enter  = (state == RUN) && cal_start;
      cal_accept = (state == CAL) && sample_valid;
      cal_last   = cal_accept && (cal_cnt == '1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         baseline  <= {1'b1, {(SW-1){1'b0}}};
         for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
         wr_ptr    <= '0;
         sum       <= '0;
         rect_q    <= '0;
         acc       <= '0;
         cal_cnt   <= '0;
         vld_pipe  <= '0;
         env_out   <= '0;
         env_valid <= 1'b0;
         cal_busy  <= 1'b0;
         cal_done  <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         cal_done  <= 1'b0;
         if (cal_enter) begin
            // Entering calibration flushes anything still in flight.
            state    <= CAL;
            cal_busy <= 1'b1;
            acc      <= '0;
            cal_cnt  <= '0;
            vld_pipe <= '0;
         end else if (state == CAL) begin
            if (cal_last) begin
               baseline <= acc_next[ACCW-1:LOG2_CAL];
               for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
               wr_ptr   <= '0;
               sum      <= '0;
               state    <= RUN;
               cal_busy <= 1'b0;
               cal_done <= 1'b1;
            end else if (cal_accept) begin
               acc     <= acc_next;
               cal_cnt <= cal_cnt + LOG2_CAL'(1);
            end
         end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], run_accept};
            if (run_accept) rect_q <= rect;
            if (vld_pipe[0]) begin
               sum             <= sum_next;
               win_buf[wr_ptr] <= rect_q;
               wr_ptr          <= wr_ptr + LOG2_WIN'(1);
            end
            if (vld_pipe[STAGES]) begin
               env_out   <= (scaled > SUMW'(255)) ? 8'hFF : scaled[7:0];
               env_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_emg_envelope.sv
// Self-checking bench for emg_envelope: randomized and directed stimulus checked
// against a windowed-average reference model of the envelope.
module tb_emg_envelope;
   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic        cal_start;
   logic [7:0]  env_out;
   logic        env_valid;
   logic        cal_busy;
   logic        cal_done;

   always #5 clk = ~clk;

   emg_envelope dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .cal_start(cal_start), .env_out(env_out), .env_valid(env_valid),
      .cal_busy(cal_busy), .cal_done(cal_done)
   );

   typedef struct {int val; int cyc;} ev_t;
   ev_t exp_q[$];
   ev_t obs_q[$];
   ev_t mon_ev;
   int  checks = 0, failures = 0;
   int  cyc = 0;
   int  base_m = 2048;
   int  hist[$];
   int  cal_acc = 0, cal_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (env_valid === 1'b1) begin
         mon_ev.val = int'(env_out);
         mon_ev.cyc = cyc;
         obs_q.push_back(mon_ev);
      end
   end

   // One clock of stimulus; inputs return idle just after the edge.
   task automatic drive(input int s, input bit v, input bit cs);
      sample_in    = 12'(s);
      sample_valid = v;
      cal_start    = cs;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      cal_start    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
   endtask

   // Reference: mean of the last 16 rectified samples since the buffer was cleared.
   task automatic send_run(input int s);
      int r, total, e;
      ev_t t;
      drive(s, 1'b1, 1'b0);
      r = s - base_m;
      if (r < 0) r = -r;
      hist.push_back(r);
      if (hist.size() > 16) void'(hist.pop_front());
      total = 0;
      foreach (hist[i]) total += hist[i];
      e = (total / 16) / 8;
      if (e > 255) e = 255;
      t.val = e;
      t.cyc = cyc + 2;
      exp_q.push_back(t);
   endtask

   task automatic start_cal(input int s, input bit v);
      drive(s, v, 1'b1);
      cal_acc = 0;
      cal_n   = 0;
   endtask

   task automatic send_cal(input int s, input bit cs);
      drive(s, 1'b1, cs);
      cal_acc += s;
      cal_n++;
      if (cal_n == 64) begin
         base_m = cal_acc / 64;
         hist.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_valid = 1'b0;
      cal_start = 1'b0;
      sample_in = '0;
      @(posedge clk); #1;
      base_m = 2048;
      hist.delete();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      @(posedge clk); #1;
      checks++;
      if (env_out !== 8'd0 || env_valid !== 1'b0 || cal_busy !== 1'b0 || cal_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got env=%0d vld=%b busy=%b done=%b want 0 0 0 0",
                  env_out, env_valid, cal_busy, cal_done);
      end
      reset = 1'b0;
      idle(1);
      send_run(2048);
      idle(4);
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL reset_first_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL reset_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < 20; i++) send_run(2848);
      idle(4);
      checks++;
      if (obs_q.size() < 20 || obs_q[0].val != 6 || obs_q[15].val != 100 || obs_q[19].val != 100) begin
         failures++;
         $display("FAIL ramp_literal: got n=%0d first=%0d n16=%0d n20=%0d want 20 6 100 100",
                  obs_q.size(), obs_q[0].val, obs_q[15].val, obs_q[19].val);
      end
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL ramp_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL ramp_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) send_run(0);
      idle(4);
      checks++;
      if (obs_q.size() < 20 || obs_q[19].val != 255) begin
         failures++;
         $display("FAIL saturate_literal: got n=%0d last=%0d want 20 255", obs_q.size(), obs_q[19].val);
      end
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL saturate_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL saturate_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 32; i++) send_run((i % 2) ? 2248 : 1848);
      for (int i = 0; i < 32; i++) begin
         send_run((i % 2) ? 2248 : 1848);
         idle(2);
      end
      idle(4);
      checks++;
      if (obs_q.size() < 64 || obs_q[31].val != 25 || obs_q[63].val != 25 ||
          obs_q[63].cyc - obs_q[62].cyc != 3) begin
         failures++;
         $display("FAIL alternate_literal: got n=%0d v32=%0d v64=%0d gap=%0d want 64 25 25 3",
                  obs_q.size(), obs_q[31].val, obs_q[63].val, obs_q[63].cyc - obs_q[62].cyc);
      end
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL alternate_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL alternate_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_cal();
      for (int i = 0; i < 3; i++) send_run(2848);
      // Two samples still in the pipe when calibration starts; they must vanish.
      drive(2848, 1'b1, 1'b0);
      drive(2848, 1'b1, 1'b0);
      start_cal(2848, 1'b1);
      checks++;
      if (cal_busy !== 1'b1) begin
         failures++;
         $display("FAIL cal_enter_busy: got %b want 1", cal_busy);
      end
      for (int i = 0; i < 64; i++) begin
         send_cal(1000, 1'b0);
         checks++;
         if (cal_busy !== (i < 63) || cal_done !== (i == 63)) begin
            failures++;
            $display("FAIL cal_flags: sample %0d got busy=%b done=%b want %b %b",
                     i + 1, cal_busy, cal_done, i < 63, i == 63);
         end
      end
      for (int i = 0; i < 16; i++) send_run(1000);
      for (int i = 0; i < 16; i++) send_run(1160);
      idle(4);
      checks++;
      if (obs_q.size() < 35 || obs_q[18].val != 0 || obs_q[34].val != 20) begin
         failures++;
         $display("FAIL cal_literal: got n=%0d zero=%0d last=%0d want 35 0 20",
                  obs_q.size(), obs_q[18].val, obs_q[34].val);
      end
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL cal_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL cal_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_cal_reset();
      int done_seen = 0;
      start_cal(0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         send_cal(1500, i == 20);
         if (i < 63 && cal_done === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0 || cal_done !== 1'b1 || cal_busy !== 1'b0) begin
         failures++;
         $display("FAIL cal_restart_ignored: got early=%0d done=%b busy=%b want 0 1 0",
                  done_seen, cal_done, cal_busy);
      end
      for (int i = 0; i < 4; i++) send_run(1660);
      idle(3);
      start_cal(0, 1'b0);
      for (int i = 0; i < 30; i++) send_cal(500, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cal_busy !== 1'b0 || cal_done !== 1'b0) begin
         failures++;
         $display("FAIL midcal_reset: got busy=%b done=%b want 0 0", cal_busy, cal_done);
      end
      reset = 1'b0;
      base_m = 2048;
      hist.delete();
      send_run(2048);
      send_run(2848);
      idle(4);
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL cal_reset_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL cal_reset_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         start_cal(0, 1'b0);
         while (cal_n < 64) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send_cal(int'($urandom_range(0, 4095)), 1'b0);
         end
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send_run(int'($urandom_range(0, 4095)));
         end
         idle(4);
      end
      while (exp_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o.val = -1; o.cyc = -1;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o.val !== e.val || o.cyc !== e.cyc) begin
            failures++;
            $display("FAIL random_env: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL random_extra_valid: got %0d extra pulses want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_saturate();
      test_alternate();
      test_cal();
      test_cal_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
